// File: rtl/cfg_bcast_pkg.sv
// Shared types and sizing for the configuration broadcast controller.
package cfg_bcast_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int NUM_CFG_WORDS = 3;
    localparam int CFG_ADDR_W    = 8;
    localparam int CFG_DATA_W    = 32;
    // Wide enough for the largest legal TIMEOUT_CYCLES of 1023.
    localparam int TIMER_W       = $clog2(1024);

endpackage

// File: rtl/cfg_timeout_cnt.sv
// Stall timer: counts consecutive stalled cycles of one write beat and flags
// the cycle in which the count has reached TIMEOUT_CYCLES-1.
module cfg_timeout_cnt
    import cfg_bcast_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count_reg;

    // Saturates at LAST_COUNT; the controller leaves SEND before it would matter.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != LAST_COUNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/cfg_bcast_ctrl.sv
// Broadcasts three initialized config words as write beats whenever init
// completes or a reload is requested from DONE/ERR, with a per-beat stall timeout.
module cfg_bcast_ctrl
    import cfg_bcast_pkg::*;
#(
    parameter logic [CFG_ADDR_W-1:0] BASE_ADDR      = 8'h10,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    input  logic [CFG_DATA_W-1:0] cfg0,
    input  logic [CFG_DATA_W-1:0] cfg1,
    input  logic [CFG_DATA_W-1:0] cfg2,
    input  logic                  reload_req,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [CFG_ADDR_W-1:0] wr_addr,
    output logic [CFG_DATA_W-1:0] wr_data,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_done_pulse,
    output logic                  load_err
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_CFG_WORDS - 1);

    state_t                state;
    logic                  init_prev;
    logic [1:0]            idx;
    logic [1:0]            next_idx;
    logic [CFG_DATA_W-1:0] shadow [NUM_CFG_WORDS];
    logic [CFG_DATA_W-1:0] cfg_in [NUM_CFG_WORDS];
    logic                  timer_clear;
    logic                  timer_inc;
    logic                  timer_expired;

    assign cfg_in[0] = cfg0;
    assign cfg_in[1] = cfg1;
    assign cfg_in[2] = cfg2;
    assign next_idx  = idx + 2'd1;

    // wr_valid is always high in SEND, so wr_ready alone marks a handshake there.
    assign timer_clear = (state == ST_CAPTURE) || ((state == ST_SEND) && wr_ready);
    assign timer_inc   = (state == ST_SEND) && !wr_ready;

    cfg_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            init_prev       <= 1'b0;
            idx             <= '0;
            wr_valid        <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            load_busy       <= 1'b0;
            load_done       <= 1'b0;
            load_done_pulse <= 1'b0;
            load_err        <= 1'b0;
            for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            init_prev       <= init_done;
            load_done_pulse <= 1'b0;
            // Losing init abandons whatever is in progress, including a pending reload.
            if ((state != ST_IDLE) && !init_done) begin
                state     <= ST_IDLE;
                wr_valid  <= 1'b0;
                load_busy <= 1'b0;
                load_done <= 1'b0;
                load_err  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (init_done && !init_prev) begin
                            state     <= ST_CAPTURE;
                            load_busy <= 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        for (int i = 0; i < NUM_CFG_WORDS; i++) begin
                            shadow[i] <= cfg_in[i];
                        end
                        // First beat takes its data straight from the inputs being snapshotted.
                        idx      <= '0;
                        wr_valid <= 1'b1;
                        wr_addr  <= BASE_ADDR;
                        wr_data  <= cfg_in[0];
                        state    <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (wr_ready) begin
                            if (idx == LAST_IDX) begin
                                wr_valid        <= 1'b0;
                                load_busy       <= 1'b0;
                                load_done       <= 1'b1;
                                load_done_pulse <= 1'b1;
                                state           <= ST_DONE;
                            end else begin
                                idx     <= next_idx;
                                wr_addr <= BASE_ADDR + CFG_ADDR_W'(next_idx);
                                wr_data <= shadow[next_idx];
                            end
                        end else if (timer_expired) begin
                            wr_valid  <= 1'b0;
                            load_busy <= 1'b0;
                            load_err  <= 1'b1;
                            state     <= ST_ERR;
                        end
                    end
                    ST_DONE: begin
                        if (reload_req) begin
                            load_done <= 1'b0;
                            load_busy <= 1'b1;
                            state     <= ST_CAPTURE;
                        end
                    end
                    ST_ERR: begin
                        if (reload_req) begin
                            load_err  <= 1'b0;
                            load_busy <= 1'b1;
                            state     <= ST_CAPTURE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cfg_bcast_ctrl.md
CFG_BCAST_CTRL -- requirements
Module: cfg_bcast_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 8'h10, write address of the first config word.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum consecutive stalled cycles per word before abort (legal range 2..1023).
REQ-003 clk  in  1  system clock; the block has one clock, all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 init_done  in  1  level from the upstream init controller; 1 = cfg0..cfg2 valid.
REQ-006 cfg0, cfg1, cfg2  in  32 each  initialized config words from the upstream init controller.
REQ-007 reload_req  in  1  single-cycle request to rebroadcast the current cfg words.
REQ-008 wr_valid  out  1  write beat valid.
REQ-009 wr_ready  in  1  downstream accepts the beat when wr_valid & wr_ready.
REQ-010 wr_addr  out  8  beat address.
REQ-011 wr_data  out  32  beat data.
REQ-012 load_busy  out  1  high in CAPTURE and SEND.
REQ-013 load_done  out  1  level, high in DONE.
REQ-014 load_done_pulse  out  1  one-cycle pulse on entry to DONE.
REQ-015 load_err  out  1  level, high in ERR.

Function
REQ-016 States are IDLE, CAPTURE, SEND, DONE and ERR; all outputs are registered.
REQ-017 IDLE -> CAPTURE on a rising edge of init_done (init_done=1, registered previous value=0); reload_req in IDLE is ignored.
REQ-018 CAPTURE lasts exactly 1 cycle: it snapshots cfg0..cfg2 into shadow registers, sets idx=0, clears the stall timer, then goes to SEND.
REQ-019 SEND: wr_valid=1, wr_addr=BASE_ADDR+idx (8-bit wrap), wr_data=shadow[idx]; addr/data stay stable while wr_valid=1 and wr_ready=0.
REQ-020 SEND, on handshake: if idx<2, idx increments, the timer clears and the next beat presents the following cycle with no bubble; if idx==2, wr_valid drops and the state goes to DONE.
REQ-021 SEND, stall: each cycle with wr_ready=0 increments the timer; when the timer reaches TIMEOUT_CYCLES-1 while still stalled, wr_valid drops and the state goes to ERR.
REQ-022 A handshake in the cycle the timer reaches TIMEOUT_CYCLES-1 takes priority over timeout.
REQ-023 From first wr_valid, 3 beats with wr_ready held high take exactly 3 cycles; load_done rises on the cycle after the third handshake.
REQ-024 DONE: load_done=1; reload_req goes to CAPTURE and clears load_done.
REQ-025 ERR: load_err=1; reload_req goes to CAPTURE and clears load_err.
REQ-026 init_done=0 in any state except IDLE forces IDLE next cycle: wr_valid, load_done and load_err clear, and no further beats are issued; this takes priority over reload_req.
REQ-027 reload_req in CAPTURE or SEND is ignored (not queued).
REQ-028 cfg changes after CAPTURE do not affect beats in flight.

Reset
REQ-029 While rst_n=0 at a clk edge: state=IDLE, idx=0, timer=0, shadows=0, init_done history=0, and all outputs are 0.
REQ-030 If init_done is already 1 when rst_n releases, the history register of 0 produces a rising edge and a broadcast starts.

Structure
REQ-031 Package cfg_bcast_pkg holds the state enum, NUM_CFG_WORDS=3, CFG_ADDR_W=8, CFG_DATA_W=32 and the timer width ($clog2 of 1024).
REQ-032 The stall timer is one sub-module, cfg_timeout_cnt, with clear, inc and expired signals; all other logic is inline.

Verification
REQ-033 cfg0..cfg2 = DEADBEEF/FEEDFACE/C001D00D, init_done rises, wr_ready=1 -> beats (10,DEADBEEF), (11,FEEDFACE), (12,C001D00D) on consecutive cycles, then load_done_pulse for 1 cycle.
REQ-034 wr_ready=0 for 5 cycles on beat 1, then 1 -> addr 11 / data FEEDFACE held stable all 5 cycles, and load_done is still reached.
REQ-035 wr_ready held 0 with TIMEOUT_CYCLES=4 -> wr_valid drops after 4 valid cycles and load_err=1; then reload_req with wr_ready=1 -> full 3-beat broadcast and load_err clears.
REQ-036 init_done drops during beat 2 -> next cycle wr_valid=0 in IDLE; init_done rises again -> a broadcast restarts from addr 10.
REQ-037 In DONE, change cfg1 to 12345678 and pulse reload_req -> beat at addr 11 carries 12345678; a reload_req pulsed mid-SEND produces no extra broadcast.
REQ-038 rst_n=0 asserted mid-SEND -> all outputs 0 at the next edge; release with init_done=1 -> a new broadcast starts.
